// File: rtl/closest_hit_reduce.sv
// closest_hit_reduce: reduces NUM_OBJ intersection beats per pixel to the nearest valid positive t.
// Optional macro CLOSEST_HIT_SEQ_CHECK_EN adds a sticky seq_error on pixel-coordinate mismatch.
module closest_hit_reduce #(
  parameter int SIZE    = 64,
  parameter int NUM_OBJ = 11,
  parameter int OBJ_W   = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [SIZE-1:0]  t_axis_tdata,
  input  logic             t_axis_undef,
  input  logic [10:0]      t_axis_hcount,
  input  logic [9:0]       t_axis_vcount,
  input  logic             t_axis_tvalid,
  output logic             t_axis_tready,
  output logic [SIZE-1:0]  hit_axis_tdata,
  output logic [OBJ_W-1:0] hit_axis_obj,
  output logic             hit_axis_miss,
  output logic [10:0]      hit_axis_hcount,
  output logic [9:0]       hit_axis_vcount,
  output logic             hit_axis_tvalid,
  input  logic             hit_axis_tready,
  output logic             seq_error
);
  localparam int EXP_W = (SIZE == 64) ? 11 : 8;
  localparam logic [OBJ_W-1:0] LAST = OBJ_W'(NUM_OBJ - 1);
  logic [OBJ_W-1:0] cnt_q, cnt_d, best_obj_q, best_obj_d, obj_d;
  logic [SIZE-1:0]  best_t_q, best_t_d, tdata_d;
  logic             best_valid_q, best_valid_d, valid_d;
  logic [10:0]      hc_q, hc_d, hcount_d;
  logic [9:0]       vc_q, vc_d, vcount_d;
  logic             accept, first, last, cand, prior, take, load;
  assign first  = cnt_q == '0;
  assign last   = cnt_q == LAST;
  assign t_axis_tready = !last || !hit_axis_tvalid || hit_axis_tready;
  assign accept = t_axis_tvalid && t_axis_tready;
  assign load   = accept && last;
  // Positive finite non-zero floats order the same as their magnitude bits read as unsigned.
  assign cand   = !t_axis_undef && !t_axis_tdata[SIZE-1] && (|t_axis_tdata[SIZE-2:0])
                  && !(&t_axis_tdata[SIZE-2 -: EXP_W]);
  assign prior  = !first && best_valid_q;
  assign take   = cand && (!prior || t_axis_tdata[SIZE-2:0] < best_t_q[SIZE-2:0]);
  always_comb begin
    cnt_d        = accept ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    best_valid_d = accept ? (prior || take) : best_valid_q;
    best_t_d     = (accept && take) ? t_axis_tdata : ((accept && first) ? '0 : best_t_q);
    best_obj_d   = (accept && take) ? cnt_q : ((accept && first) ? '0 : best_obj_q);
    hc_d         = (accept && first) ? t_axis_hcount : hc_q;
    vc_d         = (accept && first) ? t_axis_vcount : vc_q;
    valid_d      = load || (hit_axis_tvalid && !hit_axis_tready);
    tdata_d      = load ? (best_valid_d ? best_t_d : '0) : hit_axis_tdata;
    obj_d        = load ? (best_valid_d ? best_obj_d : '0) : hit_axis_obj;
    hcount_d     = load ? hc_d : hit_axis_hcount;
    vcount_d     = load ? vc_d : hit_axis_vcount;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q           <= '0;
      best_valid_q    <= 1'b0;
      best_t_q        <= '0;
      best_obj_q      <= '0;
      hc_q            <= '0;
      vc_q            <= '0;
      hit_axis_tvalid <= 1'b0;
      hit_axis_tdata  <= '0;
      hit_axis_obj    <= '0;
      hit_axis_miss   <= 1'b0;
      hit_axis_hcount <= '0;
      hit_axis_vcount <= '0;
    end else begin
      cnt_q           <= cnt_d;
      best_valid_q    <= best_valid_d;
      best_t_q        <= best_t_d;
      best_obj_q      <= best_obj_d;
      hc_q            <= hc_d;
      vc_q            <= vc_d;
      hit_axis_tvalid <= valid_d;
      hit_axis_tdata  <= tdata_d;
      hit_axis_obj    <= obj_d;
      hit_axis_miss   <= load ? !best_valid_d : hit_axis_miss;
      hit_axis_hcount <= hcount_d;
      hit_axis_vcount <= vcount_d;
    end
  end
`ifdef CLOSEST_HIT_SEQ_CHECK_EN
  logic seq_error_q;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) seq_error_q <= 1'b0;
    else if (accept && !first && (t_axis_hcount != hc_q || t_axis_vcount != vc_q)) seq_error_q <= 1'b1;
  end
  assign seq_error = seq_error_q;
`else
  assign seq_error = 1'b0;
`endif
endmodule

// File: doc/closest_hit_reduce.md
Name: closest_hit_reduce

Overview:
Per-pixel nearest-hit reducer for the multi-object renderer. Accepts a stream of intersection results, NUM_OBJ consecutive beats per pixel (object 0 first), one from each sphere/cylinder, and emits one beat per pixel: the smallest valid positive t, its object index, and a miss flag. Sits between the per-object ray_intersect stage and hit_point/lambert, replacing the single-object undef masking at the renderer output.

Parameters:
SIZE, 64, IEEE-754 float width of t (64 = double, 32 = single).
NUM_OBJ, 11, objects per pixel (1 sphere + 10 cylinders); legal range 1..256.
OBJ_W, $clog2(NUM_OBJ) min 1, width of the object index (derived; not overridden).

Ports:
aclk  in  1  clock.
aresetn  in  1  asynchronous active-low reset.
t_axis_tdata  in  SIZE  intersection distance t from ray_intersect.
t_axis_undef  in  1  1 = no real root for this object.
t_axis_hcount  in  11  pixel hcount tagged on the beat.
t_axis_vcount  in  10  pixel vcount tagged on the beat.
t_axis_tvalid  in  1  input beat valid.
t_axis_tready  out  1  input beat accepted when tvalid&tready.
hit_axis_tdata  out  SIZE  nearest valid t (0 when miss).
hit_axis_obj  out  OBJ_W  index of nearest object (0 when miss).
hit_axis_miss  out  1  1 = no object hit this pixel.
hit_axis_hcount  out  11  pixel hcount of the reduced beat.
hit_axis_vcount  out  10  pixel vcount of the reduced beat.
hit_axis_tvalid  out  1  output beat valid.
hit_axis_tready  in  1  downstream ready.
seq_error  out  1  sticky sequencing error (see Optional Feature).

Behaviour:
- Reset (aresetn low, async): obj counter=0, best_valid=0, best_t=0, best_obj=0, all hit_axis_* outputs 0, seq_error=0. Reset mid-pixel discards the partial pixel; the next accepted beat is object 0.
- Beat candidacy: beat valid iff undef=0, sign bit=0, t!=+0, and exponent field not all ones (rejects Inf/NaN). Exponent width 11 for SIZE=64, 8 for SIZE=32.
- Compare: valid positive floats compared as unsigned integers on bits [SIZE-2:0]; no float core, no added latency.
- Accumulate: on each accepted beat with counter=k: if candidate and (!best_valid or t < best_t strictly) then best_t=t, best_obj=k, best_valid=1. Ties keep the lower index.
- Counter: increments per accepted beat, wraps NUM_OBJ-1 -> 0. On object-0 beat, accumulator re-seeded from that beat alone (no carry-over from previous pixel); hcount/vcount captured from object-0 beat.
- Last beat (counter=NUM_OBJ-1): final result (including this beat) loaded into output register, hit_axis_tvalid=1 next cycle; miss=!best_valid_final; tdata/obj forced 0 on miss.
- Latency: 1 cycle from last-beat acceptance to hit_axis_tvalid. Throughput 1 input beat/cycle, 1 pixel per NUM_OBJ cycles.
- Handshake: t_axis_tready = (counter!=NUM_OBJ-1) | !hit_axis_tvalid | hit_axis_tready. Non-last beats never stall. Output held stable while tvalid&!tready. Output-register pop and load in same cycle allowed (back-to-back pixels, no bubble). hit_axis_tvalid clears on pop with no new load.
- NUM_OBJ=1: every beat is last; block degenerates to a 1-deep registered filter.

Optional Feature:
Macro CLOSEST_HIT_SEQ_CHECK_EN. With it: on every accepted beat with counter!=0, hcount/vcount compared to captured object-0 coords; mismatch sets seq_error (sticky until reset) and does not alter data flow. Without it: no comparators, seq_error tied 0.

Test Plan:
- NUM_OBJ=3, SIZE=64, pixel (5,7), t = {4.0, 2.5, 3.0} all defined -> one beat: t=0x4004000000000000, obj=1, miss=0, hcount=5, vcount=7.
- Same, undef={1,1,1} -> miss=1, t=0, obj=0; also t={-1.0, +0.0, NaN 0x7FF8000000000000} defined -> miss=1.
- Tie t={2.0, 2.0, 5.0} -> obj=0; t={+Inf, 1.0, 1.0} -> obj=1.
- Two pixels back-to-back, hit_axis_tready low for 4 cycles after first result -> object-0/1 beats of pixel 2 accepted, last beat stalled (tready=0) until pop, pixel-1 output held stable, both results correct and ordered.
- Assert aresetn low after 2 beats of a pixel -> outputs 0 immediately; next 3 beats form a complete pixel, exactly one output beat.
- With CLOSEST_HIT_SEQ_CHECK_EN, object-2 beat vcount=8 vs captured 7 -> seq_error=1 and stays 1 across later pixels; without macro seq_error=0.
